// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the sequencer state encoding, word size and default reset vector.
package kgp_fetch_pkg;

   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_HALT    = 2'd3
   } fetch_state_t;

   localparam logic [31:0] WORD_BYTES        = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

   // Branch targets are word aligned, so the low offset bits never reach the PC.
   function automatic logic [31:0] next_pc(input logic [31:0] cur_pc,
                                           input logic        taken,
                                           input logic [31:0] offset);
      logic [31:0] delta;
      if (taken) begin
         delta = {offset[31:2], 2'b00};
      end else begin
         delta = 32'd0;
      end
      next_pc = cur_pc + WORD_BYTES + delta;
   endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Issued-instruction and taken-branch event counters for the fetch sequencer.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_fire,
   input  logic        taken_fire,
   output logic [31:0] instr_cnt,
   output logic [31:0] taken_cnt
);

   // Free-running event counters, wrapping modulo 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_cnt <= 32'd0;
         taken_cnt <= 32'd0;
      end else begin
         if (issue_fire) begin
            instr_cnt <= instr_cnt + 32'd1;
         end else begin
            instr_cnt <= instr_cnt;
         end
         if (taken_fire) begin
            taken_cnt <= taken_cnt + 32'd1;
         end else begin
            taken_cnt <= taken_cnt;
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-issue instruction fetch sequencer: request, issue, resolve, halt.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
   import kgp_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] pc,
   input  logic        ex_done,
   input  logic        branch,
   input  logic [31:0] offset,
   input  logic        halt,
   output logic        halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] instr_cnt,
   output logic [31:0] taken_cnt
`endif
);

   fetch_state_t state_r;
   logic [31:0]  pc_r;
   logic [31:0]  instr_r;

   // Sequencer FSM; handshakes arriving in any other state are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_REQ;
         pc_r    <= RESET_VEC;
         instr_r <= 32'd0;
      end else begin
         case (state_r)
            ST_REQ: begin
               if (imem_ack) begin
                  instr_r <= imem_rdata;
                  state_r <= ST_ISSUE;
               end else begin
                  state_r <= ST_REQ;
               end
            end
            ST_ISSUE: begin
               if (instr_ready) begin
                  state_r <= ST_RESOLVE;
               end else begin
                  state_r <= ST_ISSUE;
               end
            end
            ST_RESOLVE: begin
               if (ex_done) begin
                  pc_r    <= next_pc(pc_r, branch, offset);
                  state_r <= halt ? ST_HALT : ST_REQ;
               end else begin
                  state_r <= ST_RESOLVE;
               end
            end
            ST_HALT: begin
               state_r <= ST_HALT;
            end
            default: begin
               state_r <= ST_REQ;
            end
         endcase
      end
   end

   // Moore outputs decode the state register directly, so reset clears them at once.
   assign imem_req    = (state_r == ST_REQ);
   assign instr_valid = (state_r == ST_ISSUE);
   assign halted      = (state_r == ST_HALT);
   assign imem_addr   = pc_r;
   assign pc          = pc_r;
   assign instr       = instr_r;

`ifdef FETCH_PERF_CNT_EN
   logic issue_fire;
   logic taken_fire;

   assign issue_fire = (state_r == ST_ISSUE) && instr_ready;
   assign taken_fire = (state_r == ST_RESOLVE) && ex_done && branch;

   fetch_perf_cnt u_perf_cnt (
      .clk        (clk),
      .rst        (rst),
      .issue_fire (issue_fire),
      .taken_fire (taken_fire),
      .instr_cnt  (instr_cnt),
      .taken_cnt  (taken_cnt)
   );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a transaction-level PC model.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] pc;
   logic        ex_done;
   logic        branch;
   logic [31:0] offset;
   logic        halt;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] instr_cnt;
   logic [31:0] taken_cnt;
`endif

   int          n_tests;
   int          n_fail;
   logic [31:0] model_pc;
   logic [31:0] model_instr_cnt;
   logic [31:0] model_taken_cnt;

   fetch_sequencer #(.RESET_VEC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc          (pc),
      .ex_done     (ex_done),
      .branch      (branch),
      .offset      (offset),
      .halt        (halt),
      .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .instr_cnt   (instr_cnt),
      .taken_cnt   (taken_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      instr_ready = 1'b0;
      ex_done     = 1'b0;
      branch      = 1'b0;
      offset      = 32'd0;
      halt        = 1'b0;
   endtask

   // One instruction end to end with stalls and stray handshakes in every phase.
   task automatic run_instr(input int ack_dly, input logic [31:0] data, input int rdy_dly,
                            input int ex_dly, input logic br, input logic [31:0] off,
                            input logic hlt);
      for (int i = 0; i < ack_dly; i++) begin
         check_eq("req_held", {31'd0, imem_req}, 32'd1);
         check_eq("req_addr", imem_addr, model_pc);
         check_eq("req_novalid", {31'd0, instr_valid}, 32'd0);
         idle_inputs();
         instr_ready = 1'($urandom_range(0, 1));
         ex_done     = 1'($urandom_range(0, 1));
         halt        = 1'($urandom_range(0, 1));
         branch      = 1'($urandom_range(0, 1));
         offset      = $urandom;
         @(negedge clk);
      end
      check_eq("req_ack_cycle", {31'd0, imem_req}, 32'd1);
      check_eq("req_ack_addr", imem_addr, model_pc);
      idle_inputs();
      imem_ack   = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      for (int i = 0; i < rdy_dly; i++) begin
         check_eq("iss_valid", {31'd0, instr_valid}, 32'd1);
         check_eq("iss_instr", instr, data);
         check_eq("iss_noreq", {31'd0, imem_req}, 32'd0);
         check_eq("iss_pc", pc, model_pc);
         idle_inputs();
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         ex_done    = 1'($urandom_range(0, 1));
         halt       = 1'($urandom_range(0, 1));
         branch     = 1'($urandom_range(0, 1));
         offset     = $urandom;
         @(negedge clk);
      end
      check_eq("iss_valid_hs", {31'd0, instr_valid}, 32'd1);
      check_eq("iss_instr_hs", instr, data);
      idle_inputs();
      instr_ready = 1'b1;
      @(negedge clk);
      model_instr_cnt = model_instr_cnt + 32'd1;
      for (int i = 0; i < ex_dly; i++) begin
         check_eq("res_novalid", {31'd0, instr_valid}, 32'd0);
         check_eq("res_noreq", {31'd0, imem_req}, 32'd0);
         check_eq("res_pc", pc, model_pc);
         idle_inputs();
         imem_ack    = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         instr_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      idle_inputs();
      ex_done = 1'b1;
      branch  = br;
      offset  = off;
      halt    = hlt;
      @(negedge clk);
      idle_inputs();
      model_pc = model_pc + 32'd4 + (br ? (off & 32'hFFFF_FFFC) : 32'd0);
      if (br) begin
         model_taken_cnt = model_taken_cnt + 32'd1;
      end
      check_eq("next_pc", pc, model_pc);
      check_eq("next_addr", imem_addr, model_pc);
      check_eq("next_halted", {31'd0, halted}, {31'd0, hlt});
      check_eq("next_req", {31'd0, imem_req}, {31'd0, ~hlt});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_pc        = 32'd0;
      model_instr_cnt = 32'd0;
      model_taken_cnt = 32'd0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_req", {31'd0, imem_req}, 32'd1);
      check_eq("rst_addr", imem_addr, 32'h0000_0000);
      check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      check_eq("rst_instr", instr, 32'd0);
      do_reset();

      // Sequential step, then a branch sequence around pc=0x20.
      run_instr(0, 32'h1234_5678, 0, 0, 1'b0, 32'd0, 1'b0);
      check_eq("seq_pc4", pc, 32'h0000_0004);
      run_instr(1, $urandom, 1, 1, 1'b1, 32'h0000_0018, 1'b0);
      check_eq("br_to20", pc, 32'h0000_0020);
      run_instr(0, $urandom, 0, 2, 1'b1, 32'hFFFF_FFF0, 1'b0);
      check_eq("br_m16", pc, 32'h0000_0014);
`ifdef FETCH_PERF_CNT_EN
      check_eq("cnt_instr3", instr_cnt, 32'd3);
      check_eq("cnt_taken2", taken_cnt, 32'd2);
`endif
      run_instr(0, $urandom, 0, 0, 1'b1, 32'h0000_0008, 1'b0);
      run_instr(0, $urandom, 0, 0, 1'b1, 32'h0000_0020, 1'b0);
      check_eq("br_p32", pc, 32'h0000_0044);
      run_instr(0, $urandom, 0, 0, 1'b1, 32'hFFFF_FFD8, 1'b0);
      run_instr(0, $urandom, 0, 0, 1'b1, 32'h0000_001E, 1'b0);
      check_eq("br_unaligned", pc, 32'h0000_0040);

      // Late ack, slow decode, stray ex_done while issuing.
      run_instr(3, 32'hCAFE_F00D, 2, 1, 1'b0, 32'd0, 1'b0);

      for (int k = 0; k < 30; k++) begin
         run_instr(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 255) - 32'd128, 1'b0);
      end
`ifdef FETCH_PERF_CNT_EN
      check_eq("cnt_instr_rand", instr_cnt, model_instr_cnt);
      check_eq("cnt_taken_rand", taken_cnt, model_taken_cnt);
`endif

      // Reset while an instruction is waiting for decode.
      idle_inputs();
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      idle_inputs();
      check_eq("mid_valid_pre", {31'd0, instr_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("mid_valid_rst", {31'd0, instr_valid}, 32'd0);
      check_eq("mid_instr_rst", instr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_pc        = 32'd0;
      model_instr_cnt = 32'd0;
      model_taken_cnt = 32'd0;
      check_eq("mid_pc", pc, 32'd0);
      check_eq("mid_req", {31'd0, imem_req}, 32'd1);
      check_eq("mid_addr", imem_addr, 32'd0);

      // Jump to the top of the address space, then halt on the wrapping step.
      run_instr(0, $urandom, 0, 0, 1'b1, 32'hFFFF_FFFC - model_pc - 32'd4, 1'b0);
      check_eq("wrap_top", pc, 32'hFFFF_FFFC);
      run_instr(1, $urandom, 1, 1, 1'b0, 32'd0, 1'b1);
      check_eq("wrap_pc0", pc, 32'h0000_0000);
      for (int i = 0; i < 8; i++) begin
         imem_ack    = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         instr_ready = 1'($urandom_range(0, 1));
         ex_done     = 1'($urandom_range(0, 1));
         branch      = 1'($urandom_range(0, 1));
         offset      = $urandom;
         halt        = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_eq("halt_halted", {31'd0, halted}, 32'd1);
         check_eq("halt_noreq", {31'd0, imem_req}, 32'd0);
         check_eq("halt_novalid", {31'd0, instr_valid}, 32'd0);
         check_eq("halt_pc", pc, 32'h0000_0000);
      end
`ifdef FETCH_PERF_CNT_EN
      check_eq("cnt_instr_end", instr_cnt, model_instr_cnt);
      check_eq("cnt_taken_end", taken_cnt, model_taken_cnt);
`endif
      do_reset();
      check_eq("rel_halted", {31'd0, halted}, 32'd0);
      check_eq("rel_req", {31'd0, imem_req}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, byte address loaded into PC on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  read address; always equals pc.
REQ-006 imem_ack  input  1  memory has returned data on imem_rdata this cycle.
REQ-007 imem_rdata  input  32  instruction word from memory.
REQ-008 instr  output  32  captured instruction presented to decode.
REQ-009 instr_valid  output  1  instr is valid and awaiting decode.
REQ-010 instr_ready  input  1  decode accepts instr this cycle.
REQ-011 pc  output  32  byte address of the current instruction.
REQ-012 ex_done  input  1  execute finished current instruction; branch, offset and halt are valid.
REQ-013 branch  input  1  taken-branch indication, qualified by ex_done.
REQ-014 offset  input  32  signed byte offset relative to pc+4, qualified by ex_done.
REQ-015 halt  input  1  stop after current instruction, qualified by ex_done.
REQ-016 halted  output  1  sequencer is in HALT.

Function
REQ-017 FSM states SHALL be REQ, ISSUE, RESOLVE, HALT; outputs imem_req, instr_valid, halted decoded from state only (Moore).
REQ-018 REQ: imem_req=1; on imem_ack, instr<=imem_rdata, next state ISSUE; otherwise remain, request held.
REQ-019 ISSUE: instr_valid=1, instr held stable; on instr_ready, next state RESOLVE.
REQ-020 RESOLVE: wait for ex_done; on ex_done, pc<=pc+4+{offset[31:2],2'b00} if branch else pc+4, modulo 2^32.
REQ-021 RESOLVE on ex_done: next state HALT if halt=1 (PC still updated), else REQ.
REQ-022 HALT SHALL be absorbing until rst; halted=1, imem_req=0, instr_valid=0, pc frozen.
REQ-023 imem_ack outside REQ, instr_ready outside ISSUE, ex_done outside RESOLVE SHALL be ignored.
REQ-024 offset[1:0] SHALL be ignored (word-aligned targets only).
REQ-025 Minimum latency: imem_ack in REQ cycle N -> instr_valid=1 in cycle N+1.
REQ-026 PC wrap: 32'hFFFF_FFFC sequential -> 32'h0000_0000, no error flag.

Reset
REQ-027 rst SHALL immediately force state REQ, pc=RESET_VEC, instr=0, abandoning any outstanding request or unaccepted instruction.
REQ-028 After reset, imem_req=1, imem_addr=RESET_VEC, instr_valid=0, halted=0.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: add outputs instr_cnt[31:0] (increments per ISSUE handshake) and taken_cnt[31:0] (increments per ex_done with branch=1 in RESOLVE), both reset to 0, wrap modulo 2^32.
REQ-030 Macro undefined: those ports and all counter logic SHALL be absent; remaining behaviour identical.

Structure
REQ-031 Package kgp_fetch_pkg SHALL hold fetch_state_t enum, WORD_BYTES=4 constant and default reset vector.
REQ-032 Counters SHALL live in sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-033 Reset: rst pulse mid-ISSUE -> same cycle instr_valid=0; after release pc=0, imem_req=1, imem_addr=0.
REQ-034 Sequential: ack with 32'h1234_5678, instr_ready=1, ex_done branch=0 -> instr=32'h1234_5678 for one valid cycle, then pc=4, imem_addr=4.
REQ-035 Branch: pc=0x20, ex_done branch=1 offset=-16 -> pc=0x14; offset=32 -> pc=0x44; offset=0x1E -> pc=0x40.
REQ-036 Stall: imem_ack 3 cycles late, instr_ready low 2 cycles, stray ex_done in ISSUE -> imem_req held, instr stable, pc unchanged.
REQ-037 Halt/wrap: pc=0xFFFF_FFFC, ex_done halt=1 branch=0 -> pc=0, halted=1, imem_req=0 until rst.
REQ-038 Counters (macro on): 3 instructions, 2 taken -> instr_cnt=3, taken_cnt=2; macro off -> build without ports.
